// File: rtl/ehl_ahb_slave_arbiter_pkg.sv
// Shared AHB definitions for the slave-port arbiter: HTRANS codes, FSM state encoding
// and helpers for deriving req/cont from a master's HTRANS.
package ehl_ahb_slave_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_BURST = 2'd2
    } arb_state_e;

    function automatic logic htrans_cont(input logic [1:0] htrans);
        return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
    endfunction

    function automatic logic htrans_req(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || htrans_cont(htrans);
    endfunction

endpackage

// File: rtl/ehl_rr_pick.sv
// Combinational round-robin picker: rotate req so rr_ptr lands on bit 0, take the
// lowest set bit, then rotate the offset back into a master index.
module ehl_rr_pick #(
    parameter int MNUM = 8,
    parameter int IDXW = 3
) (
    input  logic [MNUM-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [MNUM-1:0] win,
    output logic [IDXW-1:0] win_idx,
    output logic            valid
);

    logic [MNUM-1:0] rot;
    int              off;
    int              sum;

    always_comb begin
        rot     = MNUM'({req, req} >> rr_ptr);
        valid   = |req;
        off     = 0;
        for (int i = MNUM - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = int'(rr_ptr) + off;
        if (sum >= MNUM) sum = sum - MNUM;
        win_idx = valid ? IDXW'(sum) : '0;
        win     = '0;
        for (int j = 0; j < MNUM; j++) begin
            win[j] = valid && (sum == j);
        end
    end

endmodule

// File: rtl/ehl_ahb_slave_arbiter.sv
// Round-robin arbiter for one AHB matrix slave port: address-phase grant, data-phase ack.
// Build option EHL_AHB_ARB_BURST_HOLD_EN keeps ownership across SEQ/BUSY beats.
module ehl_ahb_slave_arbiter
    import ehl_ahb_slave_arbiter_pkg::*;
#(
    parameter int MNUM = 8,
    parameter int IDXW = 3
) (
    input  logic            hclk,
    input  logic            hresetn,
    input  logic [MNUM-1:0] req,
    input  logic [MNUM-1:0] cont,
    input  logic            is_hready,
    output logic [MNUM-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic [MNUM-1:0] ack,
    output logic [MNUM-1:0] done,
    output logic            busy
);

    arb_state_e      state, state_nxt;
    logic [MNUM-1:0] grant_nxt, ack_nxt;
    logic [IDXW-1:0] idx_nxt;
    logic [IDXW-1:0] rr_ptr, ptr_nxt;
    logic [MNUM-1:0] pick_win;
    logic [IDXW-1:0] pick_idx;
    logic            pick_vld;
    logic            rearb;

    ehl_rr_pick #(
        .MNUM(MNUM),
        .IDXW(IDXW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_vld)
    );

`ifdef EHL_AHB_ARB_BURST_HOLD_EN
    logic own_req, own_cont;
    assign own_req  = |(req & grant);
    assign own_cont = |(cont & grant);
`else
    logic unused_cont;
    assign unused_cont = ^cont;
`endif

    // rr_ptr always sits just past the owner, so the owner is scanned last and only
    // wins again when nobody else is requesting.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        ptr_nxt   = rr_ptr;
        ack_nxt   = ack;
        rearb     = 1'b0;
        if (is_hready) begin
            ack_nxt = grant & req;
            case (state)
                ST_IDLE: rearb = 1'b1;
`ifdef EHL_AHB_ARB_BURST_HOLD_EN
                ST_ADDR: begin
                    if (own_req && own_cont) state_nxt = ST_BURST;
                    else                     rearb     = 1'b1;
                end
                ST_BURST: begin
                    if (!own_cont) rearb = 1'b1;
                end
`else
                ST_ADDR:  rearb = 1'b1;
                ST_BURST: rearb = 1'b1;
`endif
                default:  rearb = 1'b1;
            endcase
            if (rearb) begin
                if (pick_vld) begin
                    state_nxt = ST_ADDR;
                    grant_nxt = pick_win;
                    idx_nxt   = pick_idx;
                    ptr_nxt   = (pick_idx == IDXW'(MNUM - 1)) ? '0 : pick_idx + 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    grant_nxt = '0;
                    idx_nxt   = '0;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ack       <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            ack       <= ack_nxt;
            rr_ptr    <= ptr_nxt;
        end
    end

    assign done = ack & {MNUM{is_hready}};
    assign busy = (|grant) | (|ack);

endmodule

// File: tb/tb_ehl_ahb_slave_arbiter.sv
// Bench for ehl_ahb_slave_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against an owner/pointer model of the round-robin rules.
module tb_ehl_ahb_slave_arbiter;

    localparam int MNUM = 8;
    localparam int IDXW = 3;
`ifdef EHL_AHB_ARB_BURST_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic            hclk = 1'b0;
    logic            hresetn = 1'b1;
    logic [MNUM-1:0] req = '0;
    logic [MNUM-1:0] cont = '0;
    logic            is_hready = 1'b0;
    logic [MNUM-1:0] grant, ack, done;
    logic [IDXW-1:0] grant_idx;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 hclk = ~hclk;

    ehl_ahb_slave_arbiter #(.MNUM(MNUM), .IDXW(IDXW)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req       (req),
        .cont      (cont),
        .is_hready (is_hready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ack       (ack),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = none), scan pointer, data-phase owner mask.
    int              m_own = -1;
    int              m_ptr = 0;
    logic [MNUM-1:0] m_ack = '0;

    function automatic int pick(input logic [MNUM-1:0] r, input int p);
        for (int k = 0; k < MNUM; k++) begin
            if (r[(p + k) % MNUM]) return (p + k) % MNUM;
        end
        return -1;
    endfunction

    function automatic logic [MNUM-1:0] onehot(input int i);
        logic [MNUM-1:0] one;
        one = 1;
        return (i >= 0) ? (one << i) : '0;
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            m_own <= -1;
            m_ptr <= 0;
            m_ack <= '0;
        end else if (is_hready) begin
            m_ack <= req & onehot(m_own);
            if (!(HOLD && m_own >= 0 && cont[m_own] && req[m_own])) begin
                m_own <= pick(req, m_ptr);
                if (req != '0) m_ptr <= (pick(req, m_ptr) + 1) % MNUM;
            end
        end
    end

    always @(negedge hclk) begin
        if (cmp_en) begin
            check("cmp_grant", grant, onehot(m_own));
            check("cmp_grant_idx", grant_idx, (m_own >= 0) ? m_own : 0);
            check("cmp_ack", ack, m_ack);
            check("cmp_done", done, m_ack & {MNUM{is_hready}});
            check("cmp_busy", busy, (m_own >= 0) || (m_ack != '0));
        end
    end

    task automatic cyc();
        @(posedge hclk);
        #2;
    endtask

    task automatic do_reset();
        hresetn   = 1'b0;
        req       = '0;
        cont      = '0;
        is_hready = 1'b0;
        cyc();
        cyc();
        hresetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MNUM-1:0] e;
        logic [MNUM-1:0] seq3 [5];
        #2;
        hresetn = 1'b0;
        #1;
        cmp_en = 1'b1;

        // 1: reset state, single request, grant then ack/done
        do_reset();
        check("rst_grant", grant, 8'h00);
        check("rst_idx", grant_idx, 0);
        check("rst_ack", ack, 8'h00);
        check("rst_busy", busy, 1'b0);
        req = 8'h01; is_hready = 1'b1;
        cyc();
        check("t1_grant", grant, 8'h01);
        check("t1_idx", grant_idx, 0);
        check("t1_ack0", ack, 8'h00);
        cyc();
        check("t1_ack", ack, 8'h01);
        check("t1_done", done, 8'h01);

        // 2: all request, grants rotate and wrap
        do_reset();
        req = 8'hFF; is_hready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cyc();
            e = 8'h01 << (k % 8);
            check("t2_grant", grant, e);
            check("t2_idx", grant_idx, k % 8);
        end

        // 3/4: master 2 burst with master 5 waiting
        if (HOLD) begin
            seq3[0] = 8'h04; seq3[1] = 8'h04; seq3[2] = 8'h04; seq3[3] = 8'h04; seq3[4] = 8'h20;
        end else begin
            seq3[0] = 8'h04; seq3[1] = 8'h20; seq3[2] = 8'h04; seq3[3] = 8'h20; seq3[4] = 8'h20;
        end
        do_reset();
        req = 8'h24; cont = 8'h00; is_hready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t3_grant", grant, seq3[k]);
            if (k == 0) cont = 8'h04;
            if (k == 3) begin req = 8'h20; cont = 8'h00; end
        end

        // 5: stall holds everything, pointer included
        do_reset();
        req = 8'h01; is_hready = 1'b1;
        cyc();
        cyc();
        is_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req = (k == 0) ? 8'h02 : (k == 1) ? 8'h40 : 8'h10;
            cyc();
            check("t5_grant_hold", grant, 8'h01);
            check("t5_ack_hold", ack, 8'h01);
            check("t5_done_low", done, 8'h00);
        end
        req = 8'h81; is_hready = 1'b1;
        cyc();
        check("t5_grant", grant, 8'h80);
        check("t5_idx", grant_idx, 7);
        check("t5_ack", ack, 8'h01);
        check("t5_done", done, 8'h01);

        // 6: async reset in the middle of a burst
        do_reset();
        req = 8'h04; is_hready = 1'b1;
        cyc();
        cont = 8'h04;
        cyc();
        cyc();
        check("t6_grant_pre", grant, 8'h04);
        check("t6_ack_pre", ack, 8'h04);
        #1;
        hresetn = 1'b0;
        #1;
        check("t6_grant_rst", grant, 8'h00);
        check("t6_ack_rst", ack, 8'h00);
        check("t6_busy_rst", busy, 1'b0);
        req = 8'h08; cont = 8'h00;
        cyc();
        hresetn = 1'b1;
        cyc();
        check("t6_grant", grant, 8'h08);
        check("t6_idx", grant_idx, 3);

        // idle release: no requests returns to no owner
        req = 8'h00;
        cyc();
        check("t7_grant_idle", grant, 8'h00);
        cyc();
        check("t7_busy_idle", busy, 1'b0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
